song_recorder: RTL and testbench
================================

# song_recorder

Captures the note-load traffic that drives the three note players and writes it, beat-timed, into a song memory as 16-bit words. Its output can later be replayed by the song reader. It sits beside the song reader / note player bus in the music player and snoops `notes_load`, `notes_to_load`, `durs_to_load` and `beat`. It drives the write port of a single-port song RAM.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10. Song RAM address width. Depth is `DEPTH = 2**ADDR_WIDTH` words.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `record_enable`  in  1  level. 1 = record; falling edge finalises the song.
- `beat`  in  1  one-cycle beat pulse from `beat_gen_ff_enabled`.
- `notes_load`  in  3  one-cycle load strobe per voice (bit i = voice i).
- `notes_to_load`  in  18  `{v2[17:12], v1[11:6], v0[5:0]}` note numbers.
- `durs_to_load`  in  18  durations, same packing.
- `wr_en`  out  1  RAM write strobe, one word per cycle.
- `wr_addr`  out  ADDR_WIDTH  RAM write address.
- `wr_data`  out  16  RAM write data.
- `recording`  out  1  high in RECORD and FLUSH.
- `full`  out  1  sticky; memory exhausted.
- `overrun`  out  1  sticky; a voice was reloaded before its previous word was written.
- `word_count`  out  ADDR_WIDTH+1  words written including the end marker.

## Operation
Word format:
- Note word: bit15=0, [14:9]=note, [8:3]=duration, [2:1]=voice (0..2), bit0=0.
- Wait word: bit15=1, [14:0]=beats elapsed (1..32767).
- End marker: 16'h8000.

States:
- IDLE: default. Goes to RECORD when `record_enable`=1. On entry clears address, `word_count`, gap, pending, `full`, `overrun`.
- RECORD: running.
  - `gap` counter (15 bit) increments on each `beat`.
  - When `gap` reaches 32767, a wait word 16'hFFFF is queued and `gap` restarts at 0.
  - When any `notes_load` bit is high:
    - if `gap`≠0 (value excluding this cycle's beat), a wait word with that gap is queued;
    - `gap` becomes 1 if `beat` is high this cycle, else 0;
    - each asserted voice's note and duration are latched into its pending register and its pending bit is set.
  - A load for a voice whose pending bit is still set overwrites that voice's data and sets `overrun`.
- Emitter: at most one word per cycle, in priority order: pending wait, voice0, voice1, voice2. Each write clears its pending flag and increments `wr_addr` and `word_count`.
- RECORD → FLUSH when `record_enable`=0.
- FLUSH: new loads are ignored. Drain pending words, then write a wait word if `gap`≠0, then write the end marker. Then go to DONE.
- Full: address DEPTH-1 is reserved for the end marker. If a data word would land at DEPTH-1, set `full`, discard all pending words and write the end marker at DEPTH-1. Then go to DONE.
- DONE: `recording`=0 and no writes. Returns to IDLE when `record_enable`=0. Re-asserting `record_enable` from IDLE starts a new recording at address 0.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `recording`=0, `full`=0, `overrun`=0, `word_count`=0, state IDLE.
- Reset mid-recording aborts immediately. No end marker is written.
- Latency:
  - Load strobe in cycle N. If no wait word is pending, the first word appears with `wr_en` in cycle N+1.
  - A 3-voice load with a gap writes 4 words in cycles N+1..N+4.
- `wr_addr`/`wr_data` are registered, valid only while `wr_en`=1. `wr_addr` of a write equals `word_count` before that write.
- `beat` in the same cycle as a load counts toward the next gap, not the one being flushed.
- `record_enable` falling in the same cycle as a load: the load is captured, then FLUSH begins.
- End marker is written exactly once per completed recording, 1 cycle after the last data word.

## Test plan
- Reset, `record_enable`=1. Load voice0 note 6'd20 dur 6'd4 at gap 0 → one write, addr 0, data 16'h2820.
- 3 beats, then `notes_load`=3'b111 → writes 16'h8003, then v0, v1, v2 note words at addr 0..3 on consecutive cycles.
- Drop `record_enable` after 2 more beats → wait word 16'h8002 then 16'h8000. `word_count`=6, `recording` falls, state DONE.
- Load voice1 twice on consecutive cycles while a wait word is being written → `overrun`=1. The voice1 word carries the second load's data.
- `ADDR_WIDTH`=2, five single-voice loads → addr 0..2 hold data, addr 3 = 16'h8000, `full`=1, no further writes.
- Assert `reset` during the emission burst → all outputs 0 next cycle, no end marker written.

Source files
------------

// File: rtl/song_recorder_if.sv
// song_recorder_if: note-load snoop bus plus the song RAM write port.
// The master side is the recorder (samples the note bus, drives the RAM write
// port); the slave side is the surrounding player/RAM environment.
interface song_recorder_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  beat;
    logic [2:0]            notes_load;
    logic [17:0]           notes_to_load;
    logic [17:0]           durs_to_load;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [15:0]           wr_data;

    modport master (
        input  beat, notes_load, notes_to_load, durs_to_load,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        output beat, notes_load, notes_to_load, durs_to_load,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/song_recorder.sv
// song_recorder: snoops note-load traffic and writes it, beat-timed, into a
// song RAM as 16-bit note / wait / end-marker words, one word per cycle.
module song_recorder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                record_enable,
    song_recorder_if.master     bus,
    output logic                recording,
    output logic                full,
    output logic                overrun,
    output logic [ADDR_WIDTH:0] word_count
);
    typedef enum logic [1:0] {S_IDLE, S_RECORD, S_FLUSH, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
    localparam logic [14:0]           GAP_MAX    = 15'h7FFF;
    localparam logic [15:0]           END_MARKER = 16'h8000;

    state_t                state_q, state_d;
    logic [14:0]           gap_q, gap_d;
    logic [2:0]            pend_q, pend_d;
    logic [2:0][5:0]       note_q, note_d;
    logic [2:0][5:0]       dur_q, dur_d;
    logic                  full_q, full_d;
    logic                  overrun_q, overrun_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]           wr_data_q, wr_data_d;
    logic                  recording_q, recording_d;

    logic                  wait_new;
    logic [14:0]           wait_val;
    logic                  have_word;
    logic                  is_end;
    logic [15:0]           word;
    logic [1:0]            sel;
    logic [2:0]            take;

    // Next-state: gap tracking, load capture, word selection and FSM transitions.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        gap_d     = gap_q;
        pend_d    = pend_q;
        note_d    = note_q;
        dur_d     = dur_q;
        full_d    = full_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wait_new  = 1'b0;
        wait_val  = gap_q;
        have_word = 1'b0;
        is_end    = 1'b0;
        word      = '0;
        sel       = 2'd0;
        take      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (record_enable) state_d = S_RECORD;
            end
            S_RECORD: begin
                if (|bus.notes_load) begin
                    // A beat coinciding with the load belongs to the next gap.
                    wait_new = (gap_q != '0);
                    gap_d    = {14'd0, bus.beat};
                end else if (bus.beat) begin
                    if (gap_q == GAP_MAX - 15'd1) begin
                        wait_new = 1'b1;
                        wait_val = GAP_MAX;
                        gap_d    = '0;
                    end else begin
                        gap_d = gap_q + 15'd1;
                    end
                end
                for (int i = 0; i < 3; i++) begin
                    if (bus.notes_load[i]) begin
                        if (pend_q[i]) overrun_d = 1'b1;
                        pend_d[i] = 1'b1;
                        note_d[i] = bus.notes_to_load[6*i +: 6];
                        dur_d[i]  = bus.durs_to_load[6*i +: 6];
                    end
                end
                if (!record_enable) state_d = S_FLUSH;
            end
            S_FLUSH: begin
            end
            S_DONE: begin
                if (!record_enable) begin
                    state_d   = S_IDLE;
                    count_d   = '0;
                    gap_d     = '0;
                    pend_d    = '0;
                    full_d    = 1'b0;
                    overrun_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Emitter: this cycle's loads are merged in so a load can be written next cycle.
        if (state_q == S_RECORD || state_q == S_FLUSH) begin
            if (wait_new) begin
                have_word = 1'b1;
                word      = {1'b1, wait_val};
            end else if (|pend_d) begin
                have_word = 1'b1;
                if (pend_d[0])      sel = 2'd0;
                else if (pend_d[1]) sel = 2'd1;
                else                sel = 2'd2;
                take[sel] = 1'b1;
                word      = {1'b0, note_d[sel], dur_d[sel], sel, 1'b0};
            end else if (state_q == S_FLUSH) begin
                have_word = 1'b1;
                if (gap_q != '0) begin
                    word  = {1'b1, gap_q};
                    gap_d = '0;
                end else begin
                    word   = END_MARKER;
                    is_end = 1'b1;
                end
            end
        end

        if (have_word) begin
            // The last address is reserved for the end marker.
            if (!is_end && count_q[ADDR_WIDTH-1:0] == LAST_ADDR) begin
                word   = END_MARKER;
                is_end = 1'b1;
                full_d = 1'b1;
                pend_d = '0;
                gap_d  = '0;
            end else begin
                pend_d = pend_d & ~take;
            end
            wr_en_d   = 1'b1;
            wr_addr_d = count_q[ADDR_WIDTH-1:0];
            wr_data_d = word;
            count_d   = count_q + (ADDR_WIDTH+1)'(1);
            if (is_end) state_d = S_DONE;
        end

        recording_d = (state_d == S_RECORD) || (state_d == S_FLUSH);
    end

    // Control state and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            pend_q      <= '0;
            full_q      <= 1'b0;
            overrun_q   <= 1'b0;
            count_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            recording_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            pend_q      <= pend_d;
            full_q      <= full_d;
            overrun_q   <= overrun_d;
            count_q     <= count_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            recording_q <= recording_d;
        end
    end

    // Voice payload registers.
    always_ff @(posedge clk) begin
        // NOTE: payload is deliberately not reset; it is only read while its pend_q bit is set.
        note_q <= note_d;
        dur_q  <= dur_d;
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign recording   = recording_q;
    assign full        = full_q;
    assign overrun     = overrun_q;
    assign word_count  = count_q;
endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder: directed stimulus with a write scoreboard per DUT.
// Expected RAM writes are queued by the stimulus and popped by monitors.
module tb_song_recorder;
    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rec_en = 1'b0;
    logic        rec_en_s = 1'b0;
    logic        recording, full, overrun;
    logic [10:0] word_count;
    logic        recording_s, full_s, overrun_s;
    logic [2:0]  word_count_s;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t exp_q[$];
    exp_t exp_s_q[$];

    song_recorder_if #(.ADDR_WIDTH(10)) m_if();
    song_recorder_if #(.ADDR_WIDTH(2))  s_if();

    song_recorder #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .record_enable(rec_en), .bus(m_if.master),
        .recording(recording), .full(full), .overrun(overrun), .word_count(word_count)
    );

    song_recorder #(.ADDR_WIDTH(2)) dut_s (
        .clk(clk), .reset(reset), .record_enable(rec_en_s), .bus(s_if.master),
        .recording(recording_s), .full(full_s), .overrun(overrun_s), .word_count(word_count_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [9:0] addr, input logic [15:0] data);
        exp_q.push_back('{addr: addr, data: data});
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        rec_en = 1'b0;
        tick(2);
        reset  = 1'b0;
    endtask

    task automatic beat_pulse();
        m_if.beat = 1'b1;
        tick(1);
        m_if.beat = 1'b0;
        tick(1);
    endtask

    // One-cycle load strobe; any beat set by the caller is held for the same cycle.
    task automatic load(input logic [2:0] mask, input logic [17:0] notes, input logic [17:0] durs);
        m_if.notes_load    = mask;
        m_if.notes_to_load = notes;
        m_if.durs_to_load  = durs;
        tick(1);
        m_if.notes_load = 3'b000;
        m_if.beat       = 1'b0;
    endtask

    // Scoreboard monitor for the 1024-word recorder.
    always @(negedge clk) begin
        if (m_if.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL main_unexpected_write: addr %h data %h, none expected", m_if.wr_addr, m_if.wr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("main_write", {6'd0, m_if.wr_addr, m_if.wr_data}, {6'd0, e.addr, e.data});
            end
        end
    end

    // Scoreboard monitor for the 4-word recorder.
    always @(negedge clk) begin
        if (s_if.wr_en === 1'b1) begin
            if (exp_s_q.size() == 0) begin
                n_total++;
                $display("FAIL small_unexpected_write: addr %h data %h, none expected", s_if.wr_addr, s_if.wr_data);
            end else begin
                exp_t e;
                e = exp_s_q.pop_front();
                check("small_write", {14'd0, s_if.wr_addr, s_if.wr_data}, {6'd0, e.addr, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        m_if.beat = 1'b0; m_if.notes_load = '0; m_if.notes_to_load = '0; m_if.durs_to_load = '0;
        s_if.beat = 1'b0; s_if.notes_load = '0; s_if.notes_to_load = '0; s_if.durs_to_load = '0;

        // Reset state.
        do_reset();
        @(negedge clk);
        check("rst_wr_en", 32'(m_if.wr_en), 32'd0);
        check("rst_wr_addr", 32'(m_if.wr_addr), 32'd0);
        check("rst_wr_data", 32'(m_if.wr_data), 32'd0);
        check("rst_recording", 32'(recording), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);

        // Single voice0 load at gap 0, record_enable dropped in the same cycle.
        rec_en = 1'b1;
        tick(1);
        @(negedge clk);
        check("t1_recording_hi", 32'(recording), 32'd1);
        push(10'd0, 16'h2820);
        push(10'd1, 16'h8000);
        rec_en = 1'b0;
        load(3'b001, {6'd0, 6'd0, 6'd20}, {6'd0, 6'd0, 6'd4});
        tick(1);
        @(negedge clk);
        check("t1_word_count", 32'(word_count), 32'd2);
        check("t1_recording_lo", 32'(recording), 32'd0);

        // Gap of 3 beats, then a 3-voice load; one word per cycle.
        do_reset();
        rec_en = 1'b1;
        tick(1);
        beat_pulse();
        beat_pulse();
        beat_pulse();
        push(10'd0, 16'h8003);
        push(10'd1, 16'h0210);
        push(10'd2, 16'h0622);
        push(10'd3, 16'h0A34);
        load(3'b111, {6'd5, 6'd3, 6'd1}, {6'd6, 6'd4, 6'd2});
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("t2_burst_count%0d", i), 32'(word_count), 32'(i));
            if (i < 4) tick(1);
        end
        // Two more beats, then stop: trailing wait word and end marker.
        beat_pulse();
        m_if.beat = 1'b1;
        tick(1);
        m_if.beat = 1'b0;
        push(10'd4, 16'h8002);
        push(10'd5, 16'h8000);
        rec_en = 1'b0;
        tick(3);
        @(negedge clk);
        check("t2_word_count", 32'(word_count), 32'd6);
        check("t2_recording_lo", 32'(recording), 32'd0);
        tick(1);
        @(negedge clk);
        check("t2_idle_cleared", 32'(word_count), 32'd0);

        // Voice1 reloaded while the wait word is written; second load carries a beat.
        do_reset();
        rec_en = 1'b1;
        tick(1);
        beat_pulse();
        push(10'd0, 16'h8001);
        push(10'd1, 16'h1252);
        load(3'b010, {6'd0, 6'd7, 6'd0}, {6'd0, 6'd8, 6'd0});
        m_if.beat = 1'b1;
        load(3'b010, {6'd0, 6'd9, 6'd0}, {6'd0, 6'd10, 6'd0});
        @(negedge clk);
        check("t4_overrun", 32'(overrun), 32'd1);
        push(10'd2, 16'h8001);
        push(10'd3, 16'h8000);
        rec_en = 1'b0;
        tick(3);
        @(negedge clk);
        check("t4_word_count", 32'(word_count), 32'd4);

        // 4-word memory: five single-voice loads fill it and stop at the marker.
        exp_s_q.push_back('{addr: 10'd0, data: 16'h0208});
        exp_s_q.push_back('{addr: 10'd1, data: 16'h0408});
        exp_s_q.push_back('{addr: 10'd2, data: 16'h0608});
        exp_s_q.push_back('{addr: 10'd3, data: 16'h8000});
        rec_en_s = 1'b1;
        tick(1);
        for (int i = 1; i <= 5; i++) begin
            s_if.notes_load    = 3'b001;
            s_if.notes_to_load = {12'd0, 6'(i)};
            s_if.durs_to_load  = 18'd1;
            tick(1);
        end
        s_if.notes_load = 3'b000;
        @(negedge clk);
        check("t5_full", 32'(full_s), 32'd1);
        check("t5_word_count", 32'(word_count_s), 32'd4);
        check("t5_recording_lo", 32'(recording_s), 32'd0);
        tick(3);
        rec_en_s = 1'b0;
        tick(2);

        // Reset during the emission burst: no further writes, no end marker.
        do_reset();
        rec_en = 1'b1;
        tick(1);
        beat_pulse();
        push(10'd0, 16'h8001);
        push(10'd1, 16'h0418);
        load(3'b111, {6'd9, 6'd5, 6'd2}, {6'd9, 6'd5, 6'd3});
        tick(1);
        reset  = 1'b1;
        rec_en = 1'b0;
        tick(1);
        @(negedge clk);
        check("t6_wr_en", 32'(m_if.wr_en), 32'd0);
        check("t6_wr_addr", 32'(m_if.wr_addr), 32'd0);
        check("t6_wr_data", 32'(m_if.wr_data), 32'd0);
        check("t6_recording", 32'(recording), 32'd0);
        check("t6_word_count", 32'(word_count), 32'd0);
        reset = 1'b0;
        tick(5);

        @(negedge clk);
        check("main_leftover", 32'(exp_q.size()), 32'd0);
        check("small_leftover", 32'(exp_s_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
